// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults and controller state encoding for the MAC feeder.
package mac_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int LEN_WIDTH_DEF = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/mac_feeder_if.sv
// mac_feeder_if: operand push, command and MAC-drive signals of the feeder.
interface mac_feeder_if import mac_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
);
  logic                  a_wr_en;
  logic [DATA_WIDTH-1:0] a_wr_data;
  logic                  a_full;
  logic                  b_wr_en;
  logic [DATA_WIDTH-1:0] b_wr_data;
  logic                  b_full;
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;
  logic                  mac_en;
  logic                  mac_clr;
  logic [DATA_WIDTH-1:0] mac_a;
  logic [DATA_WIDTH-1:0] mac_b;
  modport master (
    output a_wr_en, a_wr_data, b_wr_en, b_wr_data, start, len,
    input  a_full, b_full, busy, done, mac_en, mac_clr, mac_a, mac_b
  );
  modport slave (
    input  a_wr_en, a_wr_data, b_wr_en, b_wr_data, start, len,
    output a_full, b_full, busy, done, mac_en, mac_clr, mac_a, mac_b
  );
endinterface

// File: rtl/operand_fifo.sv
// operand_fifo: show-ahead operand FIFO; pushes while full are dropped.
module operand_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0] r_cnt;
  logic w_push, w_pop;
  assign full = r_cnt == (PW+1)'(FIFO_DEPTH);
  assign empty = r_cnt == '0;
  assign w_push = wr_en && !full;
  assign w_pop = rd_en && !empty;
  assign rd_data = r_mem[r_rptr];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt <= '0;
    end else begin
      r_wptr <= r_wptr + PW'(w_push);
      r_rptr <= r_rptr + PW'(w_pop);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
endmodule

// File: rtl/mac_feeder.sv
// mac_feeder: buffers A/B operands and streams exactly len pairs into a MAC.
module mac_feeder import mac_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  mac_feeder_if.slave io_bus
);
  state_t r_state, w_nxt;
  logic [LEN_WIDTH-1:0] r_rem, w_rem;
  logic [DATA_WIDTH-1:0] w_a_rd, w_b_rd, r_a, r_b;
  logic w_a_empty, w_b_empty, w_pop;
  logic r_busy, r_done, r_en, r_clr;
  operand_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_a_fifo (
    .clk(clk), .rst(rst), .wr_en(io_bus.a_wr_en), .wr_data(io_bus.a_wr_data),
    .rd_en(w_pop), .rd_data(w_a_rd), .full(io_bus.a_full), .empty(w_a_empty)
  );
  operand_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst), .wr_en(io_bus.b_wr_en), .wr_data(io_bus.b_wr_data),
    .rd_en(w_pop), .rd_data(w_b_rd), .full(io_bus.b_full), .empty(w_b_empty)
  );
  assign w_pop = r_state == RUN && !w_a_empty && !w_b_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_rem <= '0;
    end else begin
      r_state <= w_nxt;
      r_rem <= w_rem;
    end
  always_comb begin
    w_nxt = r_state == IDLE  ? (io_bus.start ? CLEAR : IDLE) :
            r_state == CLEAR ? (r_rem == '0 ? DONE : RUN) :
            r_state == RUN   ? ((w_pop && r_rem == LEN_WIDTH'(1)) ? DRAIN : RUN) :
            r_state == DRAIN ? DONE : IDLE;
    w_rem = (r_state == IDLE && io_bus.start) ? io_bus.len :
            w_pop ? r_rem - LEN_WIDTH'(1) : r_rem;
  end
  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_clr <= 1'b0;
      r_en <= 1'b0;
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_busy <= w_nxt != IDLE;
      r_done <= w_nxt == DONE;
      r_clr <= w_nxt == CLEAR;
      r_en <= w_pop;
      if (w_pop) begin
        r_a <= w_a_rd;
        r_b <= w_b_rd;
      end
    end
  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.mac_clr = r_clr;
  assign io_bus.mac_en = r_en;
  assign io_bus.mac_a = r_a;
  assign io_bus.mac_b = r_b;
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: directed checks of the feeder driving a reference MAC accumulator.
module tb_mac_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0, nclr = 0, ndone = 0, last_en = 0, done_at = 0;
  logic [15:0] pairs[$];
  logic [23:0] acc;
  mac_feeder_if bus ();
  mac_feeder dut (.clk(clk), .rst(rst), .io_bus(bus));
  always #5 clk = ~clk;
  // Downstream MAC: clear wins, otherwise accumulate the product when enabled.
  always @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (bus.mac_clr) acc <= '0;
    else if (bus.mac_en) acc <= acc + 24'(bus.mac_a) * 24'(bus.mac_b);
  always @(negedge clk) begin
    ncyc++;
    if (bus.mac_en) begin
      pairs.push_back({bus.mac_a, bus.mac_b});
      last_en = ncyc;
    end
    if (bus.mac_clr) nclr++;
    if (bus.done) begin
      ndone++;
      done_at = ncyc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic wa, input logic [7:0] a, input logic wb, input logic [7:0] b);
    bus.a_wr_en = wa;
    bus.a_wr_data = a;
    bus.b_wr_en = wb;
    bus.b_wr_data = b;
    tick();
    bus.a_wr_en = 1'b0;
    bus.b_wr_en = 1'b0;
  endtask
  task automatic go(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len = l;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask
  initial begin
    int cyc, e0, c0, d0, nb;
    bus.a_wr_en = 1'b0;
    bus.a_wr_data = '0;
    bus.b_wr_en = 1'b0;
    bus.b_wr_data = '0;
    bus.start = 1'b0;
    bus.len = '0;
    repeat (2) tick();
    chk("rst_busy_done", {bus.busy, bus.done}, 0);
    chk("rst_en_clr", {bus.mac_en, bus.mac_clr}, 0);
    chk("rst_ab", {bus.mac_a, bus.mac_b}, 0);
    chk("rst_full", {bus.a_full, bus.b_full}, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push(1'b1, 8'(i + 1), 1'b1, 8'(i + 5));
    e0 = pairs.size();
    c0 = nclr;
    go(4);
    chk("t1_clr", bus.mac_clr, 1);
    chk("t1_busy", bus.busy, 1);
    wait_done(cyc);
    chk("t1_lat", cyc, 7);
    chk("t1_cout", acc, 70);
    chk("t1_npairs", pairs.size() - e0, 4);
    for (int i = 0; i < 4; i++) chk("t1_pair", pairs[e0 + i], {8'(i + 1), 8'(i + 5)});
    chk("t1_nclr", nclr - c0, 1);
    tick();
    chk("t1_idle", {bus.busy, bus.done}, 0);
    e0 = pairs.size();
    go(0);
    chk("t2_clr", bus.mac_clr, 1);
    wait_done(cyc);
    chk("t2_lat", cyc, 2);
    chk("t2_cout", acc, 0);
    chk("t2_npairs", pairs.size() - e0, 0);
    tick();
    for (int i = 0; i < 3; i++) push(1'b1, 8'(10 * (i + 1)), 1'b0, 8'd0);
    e0 = pairs.size();
    go(3);
    cyc = 1;
    nb = 0;
    while (!bus.done && cyc < 300) begin
      if (cyc % 3 == 0 && nb < 3) begin
        nb++;
        bus.b_wr_en = 1'b1;
        bus.b_wr_data = 8'(nb);
      end
      tick();
      bus.b_wr_en = 1'b0;
      cyc++;
    end
    chk("t3_lat", cyc, 12);
    chk("t3_cout", acc, 140);
    chk("t3_npairs", pairs.size() - e0, 3);
    for (int i = 0; i < 3; i++) chk("t3_pair", pairs[e0 + i], {8'(10 * (i + 1)), 8'(i + 1)});
    chk("t3_done_after_en", done_at - last_en, 1);
    tick();
    for (int i = 0; i < 9; i++) begin
      push(1'b1, 8'(11 + i), i < 8, 8'd1);
      if (i == 6) chk("t4_not_full7", bus.a_full, 0);
      if (i >= 7) chk("t4_full", {bus.a_full, bus.b_full}, 3);
    end
    e0 = pairs.size();
    go(8);
    wait_done(cyc);
    chk("t4_lat", cyc, 11);
    chk("t4_cout", acc, 116);
    for (int i = 0; i < 8; i++) chk("t4_pair", pairs[e0 + i], {8'(11 + i), 8'd1});
    chk("t4_drained", bus.a_full, 0);
    tick();
    push(1'b1, 8'd100, 1'b1, 8'd1);
    go(1);
    wait_done(cyc);
    chk("t4_dropped9", acc, 100);
    tick();
    for (int i = 0; i < 5; i++) push(1'b1, 8'(i + 1), i < 2, 8'(i + 1));
    e0 = pairs.size();
    d0 = ndone;
    go(5);
    repeat (6) tick();
    chk("t5_pops", pairs.size() - e0, 2);
    chk("t5_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_ctl", {bus.busy, bus.done, bus.mac_en, bus.mac_clr}, 0);
    chk("t5_async_ab", {bus.mac_a, bus.mac_b}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_no_done", ndone - d0, 0);
    push(1'b1, 8'd7, 1'b1, 8'd3);
    e0 = pairs.size();
    go(1);
    wait_done(cyc);
    chk("t5_lat", cyc, 4);
    chk("t5_cout", acc, 21);
    chk("t5_pair", pairs[e0], {8'd7, 8'd3});
    tick();
    push(1'b1, 8'd2, 1'b1, 8'd3);
    push(1'b1, 8'd4, 1'b0, 8'd0);
    push(1'b1, 8'd6, 1'b0, 8'd0);
    e0 = pairs.size();
    d0 = ndone;
    go(3);
    repeat (3) tick();
    go(9);
    push(1'b0, 8'd0, 1'b1, 8'd5);
    push(1'b0, 8'd0, 1'b1, 8'd7);
    wait_done(cyc);
    chk("t6_done", bus.done, 1);
    chk("t6_cout", acc, 68);
    repeat (4) tick();
    chk("t6_single_done", ndone - d0, 1);
    chk("t6_npairs", pairs.size() - e0, 3);
    chk("t6_idle", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
